// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcodes, flag bit positions, FIFO state encoding.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;

   localparam int unsigned FLG_N = 3;
   localparam int unsigned FLG_Z = 2;
   localparam int unsigned FLG_C = 1;
   localparam int unsigned FLG_V = 0;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } fifo_state_e;

   function automatic logic [3:0] pack_flags(input logic n, input logic z, input logic c,
                                             input logic v);
      logic [3:0] f;
      f        = '0;
      f[FLG_N] = n;
      f[FLG_Z] = z;
      f[FLG_C] = c;
      f[FLG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry in-order FIFO with valid/ready handshakes on both sides.
// The head entry always sits in head_q so the output is a plain register.
module alu_skid_buf
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   fifo_state_e      state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             ready_en_q;
   logic             push, pop;

   // ready_en_q keeps in_ready low through reset and for the reset edge itself.
   assign in_ready  = ready_en_q && (state_q != StFull);
   assign out_valid = (state_q != StEmpty);
   assign out_data  = head_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         StEmpty: begin
            if (push) begin
               head_d  = in_data;
               state_d = StOne;
            end
         end
         StOne: begin
            case ({push, pop})
               2'b10: begin
                  tail_d  = in_data;
                  state_d = StFull;
               end
               2'b01:   state_d = StEmpty;
               2'b11:   head_d  = in_data;
               default: state_d = StOne;
            endcase
         end
         StFull: begin
            if (pop) begin
               head_d  = tail_q;
               state_d = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StEmpty;
         head_q     <= '0;
         tail_q     <= '0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         ready_en_q <= 1'b1;
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Buffers ALU results in a 2-entry FIFO and tracks sticky carry/overflow.
// Define ALU_RESULT_PERF_CNT_EN to enable the output transfer counter xfer_cnt.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_y,
   input  logic             in_carry,
   input  logic             in_overflow,
   input  logic             in_zero,
   input  logic             in_negative,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_op,
   output logic [WIDTH-1:0] out_y,
   output logic [3:0]       out_flags,
   output logic             sticky_c,
   output logic             sticky_v,
   input  logic             sticky_clr,
   output logic [31:0]      xfer_cnt
);

   localparam int unsigned PayloadW = WIDTH + 8;

   logic [PayloadW-1:0] in_payload, out_payload;
   logic                xfer;
   logic                sticky_c_q, sticky_c_d;
   logic                sticky_v_q, sticky_v_d;

   assign in_payload = {in_op, pack_flags(in_negative, in_zero, in_carry, in_overflow), in_y};

   alu_skid_buf #(
      .WIDTH(PayloadW)
   ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_payload),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_payload)
   );

   assign out_op    = out_payload[PayloadW-1 -: 4];
   assign out_flags = out_payload[WIDTH+3 -: 4];
   assign out_y     = out_payload[WIDTH-1:0];
   assign xfer      = out_valid && out_ready;

   // Clear is applied first so a same-cycle set wins.
   always_comb begin
      sticky_c_d = sticky_clr ? 1'b0 : sticky_c_q;
      sticky_v_d = sticky_clr ? 1'b0 : sticky_v_q;
      if (xfer && out_flags[FLG_C]) sticky_c_d = 1'b1;
      if (xfer && out_flags[FLG_V]) sticky_v_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_c_q <= 1'b0;
         sticky_v_q <= 1'b0;
      end else begin
         sticky_c_q <= sticky_c_d;
         sticky_v_q <= sticky_v_d;
      end
   end

   assign sticky_c = sticky_c_q;
   assign sticky_v = sticky_v_q;

`ifdef ALU_RESULT_PERF_CNT_EN
   logic [31:0] xfer_cnt_q, xfer_cnt_d;

   always_comb begin
      xfer_cnt_d = xfer_cnt_q;
      if (xfer) xfer_cnt_d = xfer_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) xfer_cnt_q <= '0;
      else        xfer_cnt_q <= xfer_cnt_d;
   end

   assign xfer_cnt = xfer_cnt_q;
`else
   assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed plus random bench for alu_result_stage, checked against a queue-based model.
module tb_alu_result_stage;

   typedef struct packed {
      logic [3:0]  op;
      logic [3:0]  fl;  // {N,Z,C,V}
      logic [31:0] y;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_y;
   logic        in_carry, in_overflow, in_zero, in_negative;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op;
   logic [31:0] out_y;
   logic [3:0]  out_flags;
   logic        sticky_c, sticky_v;
   logic        sticky_clr;
   logic [31:0] xfer_cnt;

   int total = 0;
   int bad   = 0;

   ent_t        mq[$];
   logic        m_rdy;
   logic        m_zero;
   logic        m_sc, m_sv;
   logic [31:0] m_cnt;

   alu_result_stage #(
      .WIDTH(32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_y       (in_y),
      .in_carry   (in_carry),
      .in_overflow(in_overflow),
      .in_zero    (in_zero),
      .in_negative(in_negative),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_op     (out_op),
      .out_y      (out_y),
      .out_flags  (out_flags),
      .sticky_c   (sticky_c),
      .sticky_v   (sticky_v),
      .sticky_clr (sticky_clr),
      .xfer_cnt   (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] fl,
                        input logic [31:0] y);
      in_valid    = v;
      in_op       = op;
      in_y        = y;
      in_negative = fl[3];
      in_zero     = fl[2];
      in_carry    = fl[1];
      in_overflow = fl[0];
   endtask

   // Compare outputs with the model, then advance one clock and update the model.
   task automatic step();
      logic exp_rdy, exp_vld, push, pop;
      ent_t e, h, want;
      exp_rdy = m_rdy && (mq.size() < 2);
      exp_vld = (mq.size() != 0);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(exp_vld));
      if (exp_vld || m_zero) begin
         want = exp_vld ? mq[0] : '0;
         chk("out_y", 64'(out_y), 64'(want.y));
         chk("out_op", 64'(out_op), 64'(want.op));
         chk("out_flags", 64'(out_flags), 64'(want.fl));
      end
      chk("sticky_c", 64'(sticky_c), 64'(m_sc));
      chk("sticky_v", 64'(sticky_v), 64'(m_sv));
      chk("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
      push = in_valid && exp_rdy;
      pop  = exp_vld && out_ready;
      e    = '{op: in_op, fl: {in_negative, in_zero, in_carry, in_overflow}, y: in_y};
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_rdy  = 1'b0;
         m_zero = 1'b1;
         m_sc   = 1'b0;
         m_sv   = 1'b0;
         m_cnt  = '0;
      end else begin
         m_rdy = 1'b1;
         if (sticky_clr) begin
            m_sc = 1'b0;
            m_sv = 1'b0;
         end
         if (pop) begin
            h    = mq.pop_front();
            m_sc = m_sc | h.fl[1];
            m_sv = m_sv | h.fl[0];
`ifdef ALU_RESULT_PERF_CNT_EN
            m_cnt = m_cnt + 32'd1;
`endif
         end
         if (push) begin
            mq.push_back(e);
            m_zero = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic drive_rand(input logic v);
      drive(v, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
   endtask

   initial begin
      rst_n      = 1'b0;
      out_ready  = 1'b0;
      sticky_clr = 1'b0;
      drive(1'b0, 4'h0, 4'h0, 32'h0);
      m_rdy  = 1'b0;
      m_zero = 1'b1;
      m_sc   = 1'b0;
      m_sv   = 1'b0;
      m_cnt  = '0;
      @(posedge clk);
      @(negedge clk);

      // Reset state, then first cycle out of reset.
      step();
      rst_n = 1'b1;
      step();
      chk("ready_after_reset", 64'(in_ready), 64'd1);

      // Single result through an empty stage with downstream ready.
      out_ready = 1'b1;
      drive(1'b1, 4'h2, 4'b0100, 32'h00F0_0000);
      step();
      drive(1'b0, 4'h0, 4'h0, 32'h0);
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("lat_y", 64'(out_y), 64'h00F0_0000);
      step();
      step();

      // Fill under back-pressure; third offer must be refused.
      out_ready = 1'b0;
      drive(1'b1, 4'h3, 4'b0000, 32'h0FFF_00F0);
      step();
      drive(1'b1, 4'h4, 4'b1000, 32'hFF00_FFFF);
      step();
      chk("full_in_ready", 64'(in_ready), 64'd0);
      drive(1'b1, 4'h2, 4'b0001, 32'hDEAD_BEEF);
      step();
      step();
      drive(1'b0, 4'h0, 4'h0, 32'h0);
      out_ready = 1'b1;
      step();
      chk("drain_first_gone_y", 64'(out_y), 64'hFF00_FFFF);
      step();
      step();

      // Stay in the one-entry state with push and pop every cycle.
      out_ready = 1'b0;
      drive_rand(1'b1);
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_rand(1'b1);
         step();
         chk("one_state", 64'({in_ready, out_valid}), 64'b11);
      end
      drive(1'b0, 4'h0, 4'h0, 32'h0);
      step();
      step();

      // Sticky set wins over same-cycle clear, then clear alone.
      out_ready = 1'b0;
      drive(1'b1, 4'h4, 4'b0011, 32'h1234_5678);
      step();
      drive(1'b0, 4'h0, 4'h0, 32'h0);
      out_ready  = 1'b1;
      sticky_clr = 1'b1;
      step();
      chk("sticky_set_wins", 64'({sticky_c, sticky_v}), 64'b11);
      step();
      chk("sticky_cleared", 64'({sticky_c, sticky_v}), 64'b00);
      sticky_clr = 1'b0;
      step();

      // Reset while full discards both entries.
      out_ready = 1'b0;
      drive_rand(1'b1);
      step();
      drive_rand(1'b1);
      step();
      drive(1'b0, 4'h0, 4'h0, 32'h0);
      rst_n = 1'b0;
      step();
      chk("rst_full_valid", 64'(out_valid), 64'd0);
      chk("rst_full_ready", 64'(in_ready), 64'd0);
      chk("rst_full_cnt", 64'(xfer_cnt), 64'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();
      chk("rst_release_ready", 64'(in_ready), 64'd1);

`ifdef ALU_RESULT_PERF_CNT_EN
      // Counter wrap from all-ones.
      out_ready = 1'b0;
      drive_rand(1'b1);
      step();
      drive(1'b0, 4'h0, 4'h0, 32'h0);
      force dut.xfer_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.xfer_cnt_q;
      m_cnt     = 32'hFFFF_FFFF;
      out_ready = 1'b1;
      step();
      chk("cnt_wrap", 64'(xfer_cnt), 64'd0);
      step();
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         drive_rand(1'($urandom_range(0, 1)));
         out_ready  = 1'($urandom_range(0, 3) != 0);
         sticky_clr = 1'($urandom_range(0, 7) == 0);
         step();
      end
      drive(1'b0, 4'h0, 4'h0, 32'h0);
      out_ready  = 1'b1;
      sticky_clr = 1'b0;
      step();
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the result datapath width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, upstream ALU result valid.
REQ-005 The block SHALL have port in_ready, output, 1, stage can accept a result this cycle.
REQ-006 The block SHALL have port in_op, input, 4, opcode that produced the result.
REQ-007 The block SHALL have port in_y, input, WIDTH, ALU result.
REQ-008 The block SHALL have ports in_carry, in_overflow, in_zero, in_negative, input, 1 each, ALU flags.
REQ-009 The block SHALL have port out_valid, output, 1, buffered result available.
REQ-010 The block SHALL have port out_ready, input, 1, downstream accepts.
REQ-011 The block SHALL have ports out_op (4), out_y (WIDTH), out_flags (4, bit3..0 = N,Z,C,V), outputs, head-entry contents.
REQ-012 The block SHALL have ports sticky_c, sticky_v, output, 1 each, accumulated carry/overflow.
REQ-013 The block SHALL have port sticky_clr, input, 1, clears sticky flags.
REQ-014 The block SHALL have port xfer_cnt, output, 32, count of completed output transfers.

Function
REQ-015 Input transfer SHALL occur when in_valid and in_ready are both high on a rising edge; output transfer when out_valid and out_ready are both high.
REQ-016 Storage SHALL be a 2-entry in-order FIFO; state machine EMPTY, ONE, FULL.
REQ-017 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; FULL->ONE on pop.
REQ-018 in_ready SHALL equal 1 in EMPTY and ONE, 0 in FULL (no push in FULL even with pop).
REQ-019 out_valid SHALL equal 1 in ONE and FULL, 0 in EMPTY; out_* SHALL show the oldest entry.
REQ-020 Latency SHALL be one cycle: a result pushed at edge n is visible on out_* after edge n when the FIFO was EMPTY.
REQ-021 While out_valid is high and out_ready low, out_* SHALL be held stable.
REQ-022 Data and flags SHALL pass unmodified; WIDTH bits of in_y stored bit-exact.
REQ-023 sticky_c/sticky_v SHALL be set on an output transfer whose C/V bit is 1; sticky_clr clears both; simultaneous clear and set leaves the flag set.
REQ-024 xfer_cnt SHALL increment by 1 per output transfer and wrap from 0xFFFF_FFFF to 0.

Reset
REQ-025 While rst_n is low at an edge: state EMPTY, out_valid 0, in_ready 0, out_y/out_op/out_flags 0, sticky flags 0, xfer_cnt 0.
REQ-026 in_ready SHALL be 1 from the first edge after rst_n returns high.
REQ-027 Reset mid-operation SHALL discard buffered entries; no transfer is reported for them.

Configuration
REQ-028 With ALU_RESULT_PERF_CNT_EN defined, xfer_cnt SHALL operate per REQ-024; without it, xfer_cnt SHALL be constant 0 and no counter register synthesized.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode constants (OP_AND=4'h2, OP_OR=4'h3, OP_XOR=4'h4), flag bit index constants (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0) and the FIFO state encoding.
REQ-030 The 2-entry FIFO SHALL be a sub-module alu_skid_buf parameterised by payload width; sticky flags and counter stay in alu_result_stage.

Verification
REQ-031 Push y=32'h00F0_0000, op=2, flags=0100 into EMPTY, out_ready=1 -> out_valid next cycle with identical data, xfer_cnt=1.
REQ-032 out_ready=0, push 32'h0FFF_00F0 then 32'hFF00_FFFF -> in_ready=0 after second push; third in_valid ignored; release out_ready -> both emerge in order.
REQ-033 State ONE, simultaneous push and pop for 10 cycles -> state stays ONE, 10 results in order, no loss.
REQ-034 Transfer with flags C=1,V=1 while sticky_clr=1 -> sticky_c=sticky_v=1; next cycle sticky_clr=1, no transfer -> both 0.
REQ-035 Assert rst_n=0 for one edge while FULL -> out_valid=0, in_ready=0, xfer_cnt=0; following edge in_ready=1.
REQ-036 With ALU_RESULT_PERF_CNT_EN, force counter to 0xFFFF_FFFF and complete one transfer -> xfer_cnt=0; without macro -> xfer_cnt stays 0 throughout.
